ball_mover: RTL and testbench

BALL_MOVER -- requirements
Module: ball_mover

---
 rtl/ball_mover.sv | 244 ++++++++++++++++++++++++
 tb/tb_ball_mover.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_mover.sv
// Billiard-ball mover: per-frame motion with cushion bounces and friction, plus a
// 2-stage disc renderer. Optional white stripe band selected by macro BALL_STRIPE_EN.
module ball_mover #(
    parameter int RADIUS       = 16,
    parameter int X_MIN        = 64,
    parameter int X_MAX        = 960,
    parameter int Y_MIN        = 64,
    parameter int Y_MAX        = 704,
    parameter int X_INIT       = 256,
    parameter int Y_INIT       = 384,
    parameter int VW           = 6,
    parameter int FRICTION_DIV = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 frame_tick,
    input  logic                 launch_valid,
    output logic                 launch_ready,
    input  logic signed [VW-1:0] launch_vx,
    input  logic signed [VW-1:0] launch_vy,
    input  logic [10:0]          hcount,
    input  logic [10:0]          vcount,
    input  logic [23:0]          color,
    input  logic                 striped,
    output logic [23:0]          pixel,
    output logic [10:0]          x,
    output logic [10:0]          y,
    output logic                 moving,
    output logic                 wall_hit
);

    localparam int CW = $clog2(FRICTION_DIV + 1);
    localparam logic [CW-1:0]        FRIC_LAST = CW'(FRICTION_DIV - 1);
    localparam logic signed [12:0]   X_LO = 13'(X_MIN + RADIUS);
    localparam logic signed [12:0]   X_HI = 13'(X_MAX - RADIUS);
    localparam logic signed [12:0]   Y_LO = 13'(Y_MIN + RADIUS);
    localparam logic signed [12:0]   Y_HI = 13'(Y_MAX - RADIUS);
    localparam logic signed [VW-1:0] V_MIN = {1'b1, {(VW-1){1'b0}}};
    localparam logic signed [VW-1:0] V_MAX = {1'b0, {(VW-1){1'b1}}};
    localparam logic signed [VW-1:0] V_ONE = {{(VW-1){1'b0}}, 1'b1};
    localparam logic [22:0]          R_SQ  = 23'(RADIUS * RADIUS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVING = 2'd1,
        STEP   = 2'd2,
        CHECK  = 2'd3
    } state_t;

    // Negation that keeps the most negative velocity representable.
    function automatic logic signed [VW-1:0] neg_sat(input logic signed [VW-1:0] v);
        if (v == V_MIN) begin
            neg_sat = V_MAX;
        end else begin
            neg_sat = -v;
        end
    endfunction

    function automatic logic signed [VW-1:0] toward_zero(input logic signed [VW-1:0] v);
        if (v == '0) begin
            toward_zero = v;
        end else if (v[VW-1]) begin
            toward_zero = v + V_ONE;
        end else begin
            toward_zero = v - V_ONE;
        end
    endfunction

    state_t                state_q;
    logic [10:0]           x_q, y_q;
    logic signed [VW-1:0]  vx_q, vy_q;
    logic [CW-1:0]         fric_q;
    logic signed [11:0]    nx_q, ny_q;
    logic                  launch_ready_q, moving_q, wall_hit_q;

    logic signed [12:0]    nx_ext_s, ny_ext_s;
    logic [10:0]           x_d, y_d;
    logic signed [VW-1:0]  bvx_s, bvy_s, vx_d, vy_d;
    logic                  bx_s, by_s;
    logic [CW-1:0]         fric_d;

    // Cushion resolution and friction for the CHECK cycle.
    always_comb begin
        nx_ext_s = {nx_q[11], nx_q};
        ny_ext_s = {ny_q[11], ny_q};
        if (nx_ext_s < X_LO) begin
            x_d = X_LO[10:0]; bvx_s = neg_sat(vx_q); bx_s = 1'b1;
        end else if (nx_ext_s > X_HI) begin
            x_d = X_HI[10:0]; bvx_s = neg_sat(vx_q); bx_s = 1'b1;
        end else begin
            x_d = nx_q[10:0]; bvx_s = vx_q; bx_s = 1'b0;
        end
        if (ny_ext_s < Y_LO) begin
            y_d = Y_LO[10:0]; bvy_s = neg_sat(vy_q); by_s = 1'b1;
        end else if (ny_ext_s > Y_HI) begin
            y_d = Y_HI[10:0]; bvy_s = neg_sat(vy_q); by_s = 1'b1;
        end else begin
            y_d = ny_q[10:0]; bvy_s = vy_q; by_s = 1'b0;
        end
        if (fric_q == FRIC_LAST) begin
            fric_d = '0;
            vx_d   = toward_zero(bvx_s);
            vy_d   = toward_zero(bvy_s);
        end else begin
            fric_d = fric_q + CW'(1'b1);
            vx_d   = bvx_s;
            vy_d   = bvy_s;
        end
    end

    // Motion FSM with registered handshake and status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            x_q            <= 11'(X_INIT);
            y_q            <= 11'(Y_INIT);
            vx_q           <= '0;
            vy_q           <= '0;
            fric_q         <= '0;
            nx_q           <= '0;
            ny_q           <= '0;
            launch_ready_q <= 1'b1;
            moving_q       <= 1'b0;
            wall_hit_q     <= 1'b0;
        end else begin
            wall_hit_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (launch_valid && launch_ready_q) begin
                        vx_q   <= launch_vx;
                        vy_q   <= launch_vy;
                        fric_q <= '0;
                        if ((launch_vx != '0) || (launch_vy != '0)) begin
                            state_q        <= MOVING;
                            launch_ready_q <= 1'b0;
                            moving_q       <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                MOVING: begin
                    if (frame_tick) begin
                        state_q <= STEP;
                    end else begin
                        state_q <= MOVING;
                    end
                end
                STEP: begin
                    nx_q    <= {1'b0, x_q} + {{(12-VW){vx_q[VW-1]}}, vx_q};
                    ny_q    <= {1'b0, y_q} + {{(12-VW){vy_q[VW-1]}}, vy_q};
                    state_q <= CHECK;
                end
                CHECK: begin
                    x_q        <= x_d;
                    y_q        <= y_d;
                    vx_q       <= vx_d;
                    vy_q       <= vy_d;
                    fric_q     <= fric_d;
                    wall_hit_q <= bx_s | by_s;
                    if ((vx_d == '0) && (vy_d == '0)) begin
                        state_q        <= IDLE;
                        launch_ready_q <= 1'b1;
                        moving_q       <= 1'b0;
                    end else begin
                        state_q <= MOVING;
                    end
                end
                default: begin
                    state_q        <= IDLE;
                    launch_ready_q <= 1'b1;
                    moving_q       <= 1'b0;
                end
            endcase
        end
    end

    logic [11:0] hdiff_s, vdiff_s;
    logic [10:0] dx_s, dy_s;
    logic [10:0] dx_q, dy_q;
    logic [23:0] color_q;
    logic [22:0] dsq_s;
    logic [23:0] pixel_d, pixel_q;
`ifdef BALL_STRIPE_EN
    logic        striped_q;
`else
    logic        unused_striped_s;
    assign unused_striped_s = striped;
`endif

    // Absolute raster distance to the current centre, and disc colouring.
    always_comb begin
        hdiff_s = {1'b0, hcount} - {1'b0, x_q};
        vdiff_s = {1'b0, vcount} - {1'b0, y_q};
        dx_s    = hdiff_s[11] ? (~hdiff_s[10:0] + 11'd1) : hdiff_s[10:0];
        dy_s    = vdiff_s[11] ? (~vdiff_s[10:0] + 11'd1) : vdiff_s[10:0];
        dsq_s   = ({12'd0, dx_q} * {12'd0, dx_q}) + ({12'd0, dy_q} * {12'd0, dy_q});
        pixel_d = 24'h000000;
        if (dsq_s <= R_SQ) begin
`ifdef BALL_STRIPE_EN
            if (striped_q && (dx_q < 11'd6)) begin
                pixel_d = 24'hFFFFFF;
            end else begin
                pixel_d = color_q;
            end
`else
            pixel_d = color_q;
`endif
        end else begin
            pixel_d = 24'h000000;
        end
    end

    // Two-stage pixel pipeline.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dx_q      <= '0;
            dy_q      <= '0;
            color_q   <= '0;
            pixel_q   <= '0;
`ifdef BALL_STRIPE_EN
            striped_q <= 1'b0;
`endif
        end else begin
            dx_q      <= dx_s;
            dy_q      <= dy_s;
            color_q   <= color;
            pixel_q   <= pixel_d;
`ifdef BALL_STRIPE_EN
            striped_q <= striped;
`endif
        end
    end

    assign launch_ready = launch_ready_q;
    assign moving       = moving_q;
    assign wall_hit     = wall_hit_q;
    assign x            = x_q;
    assign y            = y_q;
    assign pixel        = pixel_q;

endmodule

// File: tb/tb_ball_mover.sv
// Scoreboard bench for ball_mover: a frame-level reference model predicts each
// position update and each rendered pixel; monitors compare as the DUT presents them.
module tb_ball_mover;

    localparam int RADIUS = 16, X_MIN = 64, X_MAX = 960, Y_MIN = 64, Y_MAX = 704;
    localparam int X_INIT = 256, Y_INIT = 384, VW = 6, FD = 8;
`ifdef BALL_STRIPE_EN
    localparam bit STRIPE = 1'b1;
`else
    localparam bit STRIPE = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 frame_tick = 1'b0;
    logic                 launch_valid = 1'b0;
    logic                 launch_ready;
    logic signed [VW-1:0] launch_vx = '0, launch_vy = '0;
    logic [10:0]          hcount = '0, vcount = '0;
    logic [23:0]          color = '0;
    logic                 striped = 1'b0;
    logic [23:0]          pixel;
    logic [10:0]          x, y;
    logic                 moving, wall_hit;

    ball_mover #(
        .RADIUS(RADIUS), .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
        .X_INIT(X_INIT), .Y_INIT(Y_INIT), .VW(VW), .FRICTION_DIV(FD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
        .launch_valid(launch_valid), .launch_ready(launch_ready),
        .launch_vx(launch_vx), .launch_vy(launch_vy),
        .hcount(hcount), .vcount(vcount), .color(color), .striped(striped),
        .pixel(pixel), .x(x), .y(y), .moving(moving), .wall_hit(wall_hit)
    );

    always #5 clk = ~clk;

    typedef struct { int px; int py; bit hit; bit mov; } frame_t;
    frame_t      fq[$];
    logic [23:0] pq[$];
    int          checks = 0, errors = 0;
    bit          mon_en = 1'b1;
    bit          rv = 1'b0;

    // Reference ball state
    int mx, my, mvx, mvy, mcnt;
    bit mmov;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int negsat(input int v);
        return (v == -(1 << (VW-1))) ? (1 << (VW-1)) - 1 : -v;
    endfunction

    function automatic int toward0(input int v);
        return (v > 0) ? v - 1 : ((v < 0) ? v + 1 : 0);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        mx = X_INIT; my = Y_INIT; mvx = 0; mvy = 0; mcnt = 0; mmov = 1'b0;
    endtask

    task automatic model_frame(output frame_t e);
        int nx, ny;
        bit hit;
        hit = 1'b0;
        nx = mx + mvx;
        ny = my + mvy;
        if (nx - RADIUS < X_MIN)      begin nx = X_MIN + RADIUS; mvx = negsat(mvx); hit = 1'b1; end
        else if (nx + RADIUS > X_MAX) begin nx = X_MAX - RADIUS; mvx = negsat(mvx); hit = 1'b1; end
        if (ny - RADIUS < Y_MIN)      begin ny = Y_MIN + RADIUS; mvy = negsat(mvy); hit = 1'b1; end
        else if (ny + RADIUS > Y_MAX) begin ny = Y_MAX - RADIUS; mvy = negsat(mvy); hit = 1'b1; end
        mcnt++;
        if (mcnt == FD) begin
            mcnt = 0;
            mvx = toward0(mvx);
            mvy = toward0(mvy);
        end
        mx = nx; my = ny;
        mmov = (mvx != 0) || (mvy != 0);
        e.px = mx; e.py = my; e.hit = hit; e.mov = mmov;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_x", x, X_INIT);
        chk("rst_y", y, Y_INIT);
        chk("rst_moving", moving, 0);
        chk("rst_wall_hit", wall_hit, 0);
        chk("rst_launch_ready", launch_ready, 1);
        chk("rst_pixel", pixel, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic launch(input int vx, input int vy);
        @(negedge clk);
        launch_valid = 1'b1;
        launch_vx = VW'(vx);
        launch_vy = VW'(vy);
        @(posedge clk);
        mvx = vx; mvy = vy; mcnt = 0;
        mmov = (vx != 0) || (vy != 0);
        @(negedge clk);
        launch_valid = 1'b0;
        chk("launch_ready_after_launch", launch_ready, mmov ? 0 : 1);
        chk("moving_after_launch", moving, mmov ? 1 : 0);
    endtask

    // One frame tick; noisy adds extra ticks in STEP/CHECK and a launch attempt while busy.
    task automatic tick_frame(input bit noisy);
        frame_t e;
        @(negedge clk);
        frame_tick = 1'b1;
        if (mmov) begin
            model_frame(e);
            fq.push_back(e);
        end
        @(negedge clk);
        frame_tick = noisy;
        @(negedge clk);
        frame_tick = noisy;
        if (noisy) begin
            launch_valid = 1'b1;
            launch_vx = VW'($urandom_range(0, 63));
            launch_vy = VW'($urandom_range(0, 63));
        end
        @(negedge clk);
        frame_tick = 1'b0;
        launch_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic drive_pix(input int h, input int v, input logic [23:0] col, input bit str);
        int dx, dy;
        logic [23:0] ex;
        @(negedge clk);
        hcount = 11'(h); vcount = 11'(v); color = col; striped = str; rv = 1'b1;
        dx = iabs(h - mx);
        dy = iabs(v - my);
        if (dx * dx + dy * dy <= RADIUS * RADIUS)
            ex = (STRIPE && str && dx < 6) ? 24'hFFFFFF : col;
        else
            ex = 24'h000000;
        pq.push_back(ex);
    endtask

    task automatic pix_idle();
        @(negedge clk);
        rv = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic run_until_idle(input int limit, input bit allow_noise);
        int n;
        n = 0;
        while (mmov && n < limit) begin
            tick_frame(allow_noise ? ($urandom_range(0, 3) == 0) : 1'b0);
            n++;
        end
        chk("game_ended_within_bound", mmov ? 0 : 1, 1);
    endtask

    // Frame monitor: an accepted tick produces a position update two clocks later.
    initial begin
        frame_t e;
        forever begin
            @(posedge clk);
            if (mon_en && reset_n && frame_tick && moving) begin
                repeat (2) @(posedge clk);
                #1;
                if (fq.size() == 0) begin
                    chk("frame_unexpected_update", 1, 0);
                end else begin
                    e = fq.pop_front();
                    chk("frame_x", x, e.px);
                    chk("frame_y", y, e.py);
                    chk("frame_wall_hit", wall_hit, e.hit);
                    chk("frame_moving", moving, e.mov);
                end
                @(posedge clk);
                #1;
                chk("wall_hit_single_cycle", wall_hit, 0);
            end
        end
    end

    // Pixel monitor: compares the output two clocks after each driven raster sample.
    initial begin
        bit [1:0] pv;
        bit s;
        pv = 2'b00;
        forever begin
            @(posedge clk);
            s = rv;
            #1;
            pv = {pv[0], s};
            if (pv[1]) begin
                if (pq.size() == 0) chk("pixel_unexpected", 1, 0);
                else chk("pixel", pixel, pq.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        do_reset();

        // Basic launch and single frame
        launch(3, -2);
        tick_frame(1'b0);
        chk("first_frame_x", x, 259);
        chk("first_frame_y", y, 382);
        chk("first_frame_moving", moving, 1);

        // Friction decay to rest
        do_reset();
        launch(2, 0);
        repeat (16) tick_frame(1'b0);
        chk("friction_rest_x", x, X_INIT + 24);
        chk("friction_rest_ready", launch_ready, 1);
        chk("friction_rest_moving", moving, 0);

        // Disc edge and stripe points at the reset position
        do_reset();
        drive_pix(272, 384, 24'h12AB34, 1'b0);
        drive_pix(273, 384, 24'h12AB34, 1'b0);
        drive_pix(268, 396, 24'h12AB34, 1'b0);
        drive_pix(256, 400, 24'h00FF00, 1'b0);
        drive_pix(261, 384, 24'h3366CC, 1'b1);
        drive_pix(262, 384, 24'h3366CC, 1'b1);
        drive_pix(251, 384, 24'h3366CC, 1'b1);
        pix_idle();

        // Saturating negation at the left cushion
        launch(-32, 0);
        run_until_idle(400, 1'b0);

        // Reset during CHECK discards the update
        do_reset();
        mon_en = 1'b0;
        launch(3, 1);
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        @(negedge clk); reset_n = 1'b0;
        #1;
        chk("rst_check_x", x, X_INIT);
        chk("rst_check_wall_hit", wall_hit, 0);
        chk("rst_check_ready", launch_ready, 1);
        @(negedge clk);
        chk("rst_check_wall_hit_later", wall_hit, 0);
        reset_n = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_check_x_held", x, X_INIT);
        chk("rst_check_moving", moving, 0);
        mon_en = 1'b1;

        // Randomized games, each followed by idle ticks and pixel sampling
        for (int g = 0; g < 8; g++) begin
            int vx, vy;
            vx = int'($urandom_range(0, 63)) - 32;
            vy = int'($urandom_range(0, 63)) - 32;
            if (g < 2) begin vx = int'($urandom_range(0, 9)) - 5; vy = 0; end
            if (vx == 0 && vy == 0) vx = 1;
            launch(vx, vy);
            run_until_idle(400, 1'b1);
            tick_frame(1'b0);
            chk("idle_tick_no_move_x", x, mx);
            drive_pix(mx + RADIUS, my, 24'hA5A5A5, 1'b0);
            drive_pix(mx - RADIUS - 1, my, 24'hA5A5A5, 1'b0);
            for (int p = 0; p < 20; p++) begin
                drive_pix(mx + int'($urandom_range(0, 44)) - 22,
                          my + int'($urandom_range(0, 44)) - 22,
                          24'($urandom), $urandom_range(0, 1) == 1);
            end
            pix_idle();
        end

        repeat (6) @(negedge clk);
        chk("frame_queue_drained", fq.size(), 0);
        chk("pixel_queue_drained", pq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
